vga_solid_color: RTL and testbench



---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_timing.sv | 79 +++++++
 rtl/vga_solid_color.sv | 71 +++++++
 tb/tb_vga_solid_color.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, RGB565 pixel type and the fill palette.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    localparam int DEF_FRAMES_PER_COLOR = 60;

    typedef logic [15:0] rgb565_t;

    localparam int PALETTE_SIZE = 8;

    // white, red, green, blue, yellow, cyan, magenta, black
    localparam rgb565_t PALETTE [PALETTE_SIZE] = '{
        16'hFFFF, 16'hF800, 16'h07E0, 16'h001F,
        16'hFFE0, 16'h07FF, 16'hF81F, 16'h0000
    };

    function automatic logic in_range(
        input logic [CNT_W-1:0] value,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate enable, horizontal/vertical counters and registered sync pulses for one VGA mode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_active,
    output logic o_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT        = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);

    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT        = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic             r_pix_en;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             r_hsync;
    logic             r_vsync;

    logic w_h_last;
    logic w_v_last;
    logic w_in_hsync;
    logic w_in_vsync;

    assign w_h_last   = (r_h_cnt == H_LAST);
    assign w_v_last   = (r_v_cnt == V_LAST);
    assign w_in_hsync = in_range(r_h_cnt, H_SYNC_START, H_SYNC_END);
    assign w_in_vsync = in_range(r_v_cnt, V_SYNC_START, V_SYNC_END);

    // One pixel spans two system clocks; the counters move only on the enabled half.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix_en <= 1'b0;
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
        end else begin
            r_pix_en <= ~r_pix_en;
            r_hsync  <= ~w_in_hsync;
            r_vsync  <= ~w_in_vsync;
            if (r_pix_en) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
                end else begin
                    r_h_cnt <= r_h_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_hsync     = r_hsync;
    assign o_vsync     = r_vsync;
    assign o_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_frame_end = r_pix_en && w_h_last && w_v_last;

endmodule

// File: rtl/vga_solid_color.sv
// VGA display demo: full-screen solid fill that steps through the palette every few frames.
module vga_solid_color
    import vga_pkg::*;
#(
    parameter int H_ACTIVE         = DEF_H_ACTIVE,
    parameter int H_FRONT          = DEF_H_FRONT,
    parameter int H_SYNC           = DEF_H_SYNC,
    parameter int H_BACK           = DEF_H_BACK,
    parameter int V_ACTIVE         = DEF_V_ACTIVE,
    parameter int V_FRONT          = DEF_V_FRONT,
    parameter int V_SYNC           = DEF_V_SYNC,
    parameter int V_BACK           = DEF_V_BACK,
    parameter int FRAMES_PER_COLOR = DEF_FRAMES_PER_COLOR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb
);

    localparam int FC_W = $clog2(FRAMES_PER_COLOR + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_COLOR - 1);

    logic w_active;
    logic w_frame_end;

    logic [FC_W-1:0] r_frame_cnt;
    logic [2:0]      r_color_idx;
    rgb565_t         r_rgb;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_hsync     (hsync),
        .o_vsync     (vsync),
        .o_active    (w_active),
        .o_frame_end (w_frame_end)
    );

    // The colour index only moves on the last pixel of a frame, so a frame is always one colour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_color_idx <= '0;
            r_rgb       <= '0;
        end else begin
            r_rgb <= w_active ? PALETTE[r_color_idx] : rgb565_t'(0);
            if (w_frame_end) begin
                if (r_frame_cnt == FC_LAST) begin
                    r_frame_cnt <= '0;
                    r_color_idx <= r_color_idx + 3'd1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FC_W'(1);
                end
            end
        end
    end

    assign rgb = r_rgb;

endmodule

// File: tb/tb_vga_solid_color.sv
// Directed bench for vga_solid_color on a shrunken 16x9-pixel mode so many frames fit in a short run.
module tb_vga_solid_color;

    // Small mode: h sync on 10..12 (total 16), v sync on lines 5..6 (total 9); 288 clk per frame.
    localparam int MAX_REC = 5000;

    logic        clk;
    logic        rst_n;
    logic        hsync;
    logic        vsync;
    logic [15:0] rgb;

    int checkCount = 0;
    int errorCount = 0;
    int numRec = 0;

    logic        hsArr  [0:MAX_REC-1];
    logic        vsArr  [0:MAX_REC-1];
    logic [15:0] rgbArr [0:MAX_REC-1];

    logic [15:0] frameColor [0:16] = '{
        16'hFFFF, 16'hFFFF, 16'hF800, 16'hF800, 16'h07E0, 16'h07E0,
        16'h001F, 16'h001F, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07FF,
        16'hF81F, 16'hF81F, 16'h0000, 16'h0000, 16'hFFFF
    };

    vga_solid_color #(
        .H_ACTIVE         (8),
        .H_FRONT          (2),
        .H_SYNC           (3),
        .H_BACK           (3),
        .V_ACTIVE         (4),
        .V_FRONT          (1),
        .V_SYNC           (2),
        .V_BACK           (2),
        .FRAMES_PER_COLOR (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hsync (hsync),
        .vsync (vsync),
        .rgb   (rgb)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstLevel);
        @(negedge clk);
        rst_n = rstLevel;
    endtask

    // Index k holds the outputs sampled just after the k-th rising edge following release.
    task automatic recordRun(input int cycles);
        numRec = cycles;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk);
            #1;
            hsArr[k]  = hsync;
            vsArr[k]  = vsync;
            rgbArr[k] = rgb;
        end
    endtask

    function automatic int findEdge(input int from, input bit useVsync, input logic level);
        for (int k = from + 1; k <= numRec; k++) begin
            if (useVsync) begin
                if (vsArr[k] == level && vsArr[k-1] != level) return k;
            end else begin
                if (hsArr[k] == level && hsArr[k-1] != level) return k;
            end
        end
        return -1;
    endfunction

    function automatic int countValue(input int first, input int last, input logic [15:0] value);
        int n = 0;
        for (int k = first; k <= last; k++) begin
            if (rgbArr[k] == value) n++;
        end
        return n;
    endfunction

    initial begin
        int hsFall;
        int hsRise;
        int vsFall;
        int vsRise;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hsync", 32'(hsync), 32'd1);
            checkOutput("reset_vsync", 32'(vsync), 32'd1);
            checkOutput("reset_rgb", 32'(rgb), 32'h0000);
        end

        applyStimulus(1'b1);
        recordRun(17 * 288);

        checkOutput("first_pixel_rgb", 32'(rgbArr[1]), 32'hFFFF);
        checkOutput("first_pixel_hsync", 32'(hsArr[1]), 32'd1);

        hsFall = findEdge(1, 1'b0, 1'b0);
        hsRise = findEdge(hsFall, 1'b0, 1'b1);
        checkOutput("hsync_first_fall", 32'(hsFall), 32'd21);
        checkOutput("hsync_first_rise", 32'(hsRise), 32'd27);
        checkOutput("hsync_second_fall", 32'(findEdge(hsRise, 1'b0, 1'b0)), 32'd53);

        vsFall = findEdge(1, 1'b1, 1'b0);
        vsRise = findEdge(vsFall, 1'b1, 1'b1);
        checkOutput("vsync_first_fall", 32'(vsFall), 32'd161);
        checkOutput("vsync_first_rise", 32'(vsRise), 32'd225);
        checkOutput("vsync_second_fall", 32'(findEdge(vsRise, 1'b1, 1'b0)), 32'd449);
        checkOutput("vsync_line_aligned", 32'((vsFall - 1) % 32), 32'd0);

        checkOutput("line0_white_clks", 32'(countValue(1, 32, 16'hFFFF)), 32'd16);
        checkOutput("line0_blank_clks", 32'(countValue(1, 32, 16'h0000)), 32'd16);
        checkOutput("line3_white_clks", 32'(countValue(97, 128, 16'hFFFF)), 32'd16);
        checkOutput("vblank_lines_black", 32'(countValue(129, 288, 16'h0000)), 32'd160);

        for (int f = 0; f <= 16; f++) begin
            checkOutput($sformatf("frame%0d_first_pixel", f), 32'(rgbArr[1 + 288 * f]), 32'(frameColor[f]));
            checkOutput($sformatf("frame%0d_last_pixel", f), 32'(rgbArr[112 + 288 * f]), 32'(frameColor[f]));
        end

        // Restart and run into frame 3, stopping on a pixel inside the horizontal sync pulse.
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        recordRun(919);
        checkOutput("frame3_mid_line_rgb", 32'(rgbArr[905]), 32'hF800);
        checkOutput("frame3_in_hsync", 32'(hsArr[919]), 32'd0);

        applyStimulus(1'b0);
        @(posedge clk);
        #1;
        checkOutput("midreset_hsync", 32'(hsync), 32'd1);
        checkOutput("midreset_vsync", 32'(vsync), 32'd1);
        checkOutput("midreset_rgb", 32'(rgb), 32'h0000);

        applyStimulus(1'b1);
        recordRun(600);
        checkOutput("restart_first_pixel", 32'(rgbArr[1]), 32'hFFFF);
        checkOutput("restart_hsync_fall", 32'(findEdge(1, 1'b0, 1'b0)), 32'd21);
        checkOutput("restart_frame1_rgb", 32'(rgbArr[289]), 32'hFFFF);
        checkOutput("restart_frame2_rgb", 32'(rgbArr[577]), 32'hF800);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
